// File: rtl/cla_ctrl_pkg.sv
// cla_ctrl_pkg
//   Shared definitions for the CLA slice sequencing controller:
//   default operand/slice widths, the controller state encoding, and the
//   two's-complement overflow rule used when the result is presented.
package cla_ctrl_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow: both operands share a sign and the result does not.
    function automatic logic ovf_of(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_seq_ctrl_slice_sel.sv
// slice_sel
//   Combinational access to slice idx_i of a WIDTH-bit word.
//   Ports:
//     word_i  - WIDTH-bit source word
//     idx_i   - slice index (0 = least-significant slice)
//     slice_i - SLICE-bit value to insert at slice idx_i
//     slice_o - slice idx_i extracted from word_i
//     word_o  - word_i with slice idx_i replaced by slice_i
module slice_sel
    import cla_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE,
    localparam int NSLICE = WIDTH / SLICE,
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [SLICE-1:0] slice_i,
    output logic [SLICE-1:0] slice_o,
    output logic [WIDTH-1:0] word_o
);

    assign slice_o = word_i[idx_i*SLICE +: SLICE];

    always_comb begin
        word_o = word_i;
        word_o[idx_i*SLICE +: SLICE] = slice_i;
    end

endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl
//   Time-multiplexes one external SLICE-bit carry-lookahead adder slice
//   across a WIDTH-bit addition, least-significant slice first, one slice
//   per clock, with the inter-slice carry held in a flop.
//   Ports:
//     clk, reset_n          - clock, asynchronous active-low reset
//     sync_clear            - synchronous abort back to IDLE
//     in_valid/in_ready     - operand handshake (a, b, cin)
//     out_valid/out_ready   - result handshake (sum, cout, ovf)
//     cla_a/cla_b/cla_cin   - operands driven to the shared slice
//     cla_sum/cla_cout      - combinational result from the shared slice
module cla_seq_ctrl
    import cla_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [SLICE-1:0] cla_a,
    output logic [SLICE-1:0] cla_b,
    output logic             cla_cin,
    input  logic [SLICE-1:0] cla_sum,
    input  logic             cla_cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [WIDTH-1:0] sum_ins;

    // Outputs of the shared helper that a given instance has no use for.
    logic [WIDTH-1:0] unused_a_word;
    logic [WIDTH-1:0] unused_b_word;
    logic [SLICE-1:0] unused_sum_slice;

    slice_sel #(.WIDTH(WIDTH), .SLICE(SLICE)) u_sel_a (
        .word_i  (a_q),
        .idx_i   (idx_q),
        .slice_i ('0),
        .slice_o (a_slice),
        .word_o  (unused_a_word)
    );

    slice_sel #(.WIDTH(WIDTH), .SLICE(SLICE)) u_sel_b (
        .word_i  (b_q),
        .idx_i   (idx_q),
        .slice_i ('0),
        .slice_o (b_slice),
        .word_o  (unused_b_word)
    );

    slice_sel #(.WIDTH(WIDTH), .SLICE(SLICE)) u_ins_sum (
        .word_i  (sum_q),
        .idx_i   (idx_q),
        .slice_i (cla_sum),
        .slice_o (unused_sum_slice),
        .word_o  (sum_ins)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        if (sync_clear) begin
            // Abort wins over every transition; the partially built sum is
            // left in place but never presented.
            state_d = ST_IDLE;
            idx_d   = '0;
            carry_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        carry_d = cin;
                        idx_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_d   = sum_ins;
                    carry_d = cla_cout;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_d  = cla_cout;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags depend on state only, never on the partner's signal.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    assign cla_a   = (state_q == ST_RUN) ? a_slice : '0;
    assign cla_b   = (state_q == ST_RUN) ? b_slice : '0;
    assign cla_cin = (state_q == ST_RUN) ? carry_q : 1'b0;

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = (state_q == ST_DONE) &&
                  ovf_of(a_q[WIDTH-1], b_q[WIDTH-1], sum_q[WIDTH-1]);

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl
//   Drives the sequencing controller with directed operand vectors and a
//   4-bit carry-lookahead slice built into the bench. A transaction-level
//   model predicts handshake flags, slice operands and results each cycle.
module tb_cla_seq_ctrl;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int NS = W / S;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sync_clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [S-1:0]  cla_a;
    logic [S-1:0]  cla_b;
    logic          cla_cin;
    logic [S-1:0]  cla_sum;
    logic          cla_cout;

    cla_seq_ctrl #(.WIDTH(W), .SLICE(S)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_clear (sync_clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .ovf        (ovf),
        .cla_a      (cla_a),
        .cla_b      (cla_b),
        .cla_cin    (cla_cin),
        .cla_sum    (cla_sum),
        .cla_cout   (cla_cout)
    );

    always #5 clk = ~clk;

    // 4-bit carry-lookahead slice
    logic [3:0] g, p;
    logic [4:0] c;
    always_comb begin
        g = cla_a & cla_b;
        p = cla_a ^ cla_b;
        c = '0;
        c[0] = cla_cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        cla_sum  = p ^ c[3:0];
        cla_cout = c[4];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 working (k slices done), 2 result held.
    int           cyc  = 0;
    int           m_ph = 0;
    int           m_k  = 0;
    logic [W-1:0] ma, mb;
    logic         mc;
    logic [W:0]   m_full;
    logic         m_ovf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph = 0;
            m_k  = 0;
        end else begin
            cyc = cyc + 1;
            if (sync_clear) begin
                m_ph = 0;
            end else if (m_ph == 0) begin
                if (in_valid) begin
                    ma = a; mb = b; mc = cin;
                    m_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    m_ovf  = (a[W-1] == b[W-1]) && (m_full[W-1] != a[W-1]);
                    m_k  = 0;
                    m_ph = 1;
                end
            end else if (m_ph == 1) begin
                m_k++;
                if (m_k == NS) m_ph = 2;
            end else begin
                if (out_ready) m_ph = 0;
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_ph == 0);
            chk("out_valid", out_valid, m_ph == 2);
            if (m_ph == 2) begin
                chk("model_sum", sum, m_full[W-1:0]);
                chk("model_cout", cout, m_full[W]);
                chk("model_ovf", ovf, m_ovf);
            end
            if (m_ph == 1) begin
                automatic int unsigned msk = (32'd1 << (S * m_k)) - 1;
                automatic int unsigned cx =
                    ((({16'd0, ma} & msk) + ({16'd0, mb} & msk) + mc) >> (S * m_k)) & 1;
                chk("cla_a", cla_a, (ma >> (S * m_k)) & 4'hF);
                chk("cla_b", cla_b, (mb >> (S * m_k)) & 4'hF);
                chk("cla_cin", cla_cin, cx);
            end else begin
                chk("cla_idle", {cla_a, cla_b, cla_cin}, 0);
            end
        end
    end

    // Accept edges and accepted results as seen at the DUT pins.
    int          dut_acc[$];
    logic [17:0] res_q[$];
    always @(negedge clk) begin
        if (reset_n && in_ready && in_valid && !sync_clear) dut_acc.push_back(cyc + 1);
        if (reset_n && out_valid && out_ready) res_q.push_back({ovf, cout, sum});
    end

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                           input logic [W-1:0] es, input logic ec, input logic eo,
                           input int hold, input bit poke);
        int t_acc;
        logic [W-1:0] s0;
        @(posedge clk); #1;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_acc = cyc;
        if (poke) begin
            a = ~ta; b = ~tb_; cin = ~tc; in_valid = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("out_valid_seen", out_valid, 1);
        chk("latency", cyc - t_acc, NS);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("ovf", ovf, eo);
        s0 = sum;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_sum", sum, s0);
            chk("hold_cout", cout, ec);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, r0;
        reset_n = 1'b0; sync_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout_ovf", {cout, ovf}, 0);
        chk("rst_cla", {cla_a, cla_b, cla_cin}, 0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Basic add and carry ripple cases
        run_txn(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        run_txn(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);

        // Backpressure held 3 cycles, plus operands offered mid-run
        run_txn(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 3, 1'b1);

        // Abort during the idx=2 cycle
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sync_clear = 1'b1;
        @(negedge clk);
        chk("abort_cla_a_idx2", cla_a, 4'hA);
        chk("abort_cla_b_idx2", cla_b, 4'h1);
        @(posedge clk); #1;
        sync_clear = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
        run_txn(16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 0, 1'b0);

        // Asynchronous reset between clock edges mid-run
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout_ovf", {cout, ovf}, 0);
        chk("arst_cla", {cla_a, cla_b, cla_cin}, 0);
        #1;
        reset_n = 1'b1;
        run_txn(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0);

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        n0 = dut_acc.size();
        r0 = res_q.size();
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h8000; b = 16'h8000; cin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (dut_acc.size() >= n0 + 2) break;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (res_q.size() >= r0 + 2) break;
            @(negedge clk);
        end
        chk("b2b_accepts", dut_acc.size() - n0, 2);
        chk("b2b_results", res_q.size() - r0, 2);
        if (dut_acc.size() >= n0 + 2)
            chk("b2b_gap", dut_acc[n0 + 1] - dut_acc[n0], NS + 2);
        if (res_q.size() >= r0 + 2) begin
            chk("b2b_res0", res_q[r0], {1'b0, 1'b0, 16'h3333});
            chk("b2b_res1", res_q[r0 + 1], {1'b1, 1'b1, 16'h0001});
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
